karatsuba_10b: RTL and testbench
================================

KARATSUBA_10B -- requirements
Module: karatsuba_10b

Interface
REQ-001 Parameters: none; operand width fixed at 10 bits, product at 20 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; level sampled on rising clk edge.
REQ-005 a  input  10  unsigned multiplicand; sampled only on the accepting edge.
REQ-006 b  input  10  unsigned multiplier; sampled only on the accepting edge.
REQ-007 s  output  20  unsigned product a*b, registered.
REQ-008 done  output  1  high while s holds the result of the most recently accepted operation.

Function
REQ-009 States SHALL be IDLE, MUL_LO, MUL_HI, MUL_MID, COMBINE, DONE.
REQ-010 In IDLE or DONE, start=1 at a rising edge SHALL be accepted: capture a and b, clear done, enter MUL_LO (or MUL when KARATSUBA_SHARED_MUL_EN is undefined).
REQ-011 start SHALL be ignored in all other states; holding start high for several cycles SHALL start exactly one operation.
REQ-012 Split: a1=a[9:5], a0=a[4:0], b1=b[9:5], b0=b[4:0].
REQ-013 MUL_LO: p0 <= a0*b0 (10 bits); go to MUL_HI.
REQ-014 MUL_HI: p2 <= a1*b1 (10 bits); go to MUL_MID.
REQ-015 MUL_MID: pm <= (a1+a0)*(b1+b0), with 6-bit sums and a 12-bit product; go to COMBINE.
REQ-016 COMBINE: s <= (p2<<10) + ((pm-p2-p0)<<5) + p0, using an 11-bit middle term that is never negative; set done=1; go to DONE.
REQ-017 The multiplication SHALL use the Karatsuba decomposition only; there SHALL be no direct 10x10 multiply.
REQ-018 s SHALL be exact for all 2^20 operand pairs, with no truncation.
REQ-019 Latency with the shared multiplier: done rises on the 4th rising edge after the accepting edge.
REQ-020 s and done SHALL hold stable in DONE until the next accepted start.
REQ-021 s SHALL retain its old value while an operation is in progress; only done indicates validity.
REQ-022 A start arriving in the same cycle COMBINE completes SHALL be ignored; it is accepted in DONE if still asserted.

Reset
REQ-023 While rst_n=0, the block SHALL immediately force state=IDLE, done=0, s=0, and all internal products and operand registers to 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no result; the first accepted start after release begins a fresh operation.
REQ-025 The block SHALL leave reset release synchronised to clk externally; start is not sampled while rst_n=0.

Configuration
REQ-026 Macro KARATSUBA_SHARED_MUL_EN defined SHALL select a single shared 6x6 multiplier, time-multiplexed through MUL_LO, MUL_HI and MUL_MID.
REQ-027 Macro KARATSUBA_SHARED_MUL_EN undefined SHALL select three parallel multipliers. MUL_LO, MUL_HI and MUL_MID collapse into a single MUL state that computes p0, p2 and pm together. done rises on the 2nd rising edge after the accepting edge.
REQ-028 Results, the handshake and reset behaviour SHALL be identical in both configurations; only latency differs.

Verification
REQ-029 Reset low, then release, with no start -> done=0 and s=0 indefinitely.
REQ-030 a=1023, b=1023, start held 2 cycles -> done rises after the configured latency, and s=1046529 (0xFF801) held until the next start.
REQ-031 Carry boundaries -> (a=31,b=31) gives 961; (a=32,b=32) gives 1024; (a=1023,b=1) gives 1023; (a=0,b=777) gives 0; the middle term must reach its maximum without overflow.
REQ-032 Back-to-back: operation A completes, then start with new operands -> done falls on the accepting edge, and s updates only when done rises again.
REQ-033 Reset pulse while in MUL_HI (a=600,b=700) -> s=0 and done=0 immediately; the next start with a=600, b=700 gives s=420000.
REQ-034 1000 random operand pairs with a 2-cycle start and wait-for-done -> zero mismatches against a*b, in both macro settings.

Source files
------------

// File: rtl/karatsuba_10b.sv
// karatsuba_10b
//   Sequential 10x10 unsigned multiplier built from a one-level Karatsuba
//   decomposition into 5-bit halves. No 10x10 multiply is ever formed.
//
//   Configuration macro: KARATSUBA_SHARED_MUL_EN
//     defined   : one 6x6 multiplier shared across MUL_LO, MUL_HI and MUL_MID
//                 (done rises on the 4th rising edge after the accepting edge)
//     undefined : three parallel multipliers evaluated in a single MUL state
//                 (done rises on the 2nd rising edge after the accepting edge)
//
//   Ports
//     clk    in   1   clock, rising edge
//     rst_n  in   1   asynchronous active-low reset
//     start  in   1   request; accepted in IDLE or DONE
//     a      in  10   unsigned multiplicand, captured on the accepting edge
//     b      in  10   unsigned multiplier, captured on the accepting edge
//     s      out 20   registered product a*b
//     done   out  1   s holds the result of the most recently accepted operation
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no result yet, waiting for start
//   MUL_LO  | p0 <= a0*b0                      (shared multiplier only)
//   MUL_HI  | p2 <= a1*b1                      (shared multiplier only)
//   MUL_MID | pm <= (a1+a0)*(b1+b0)           (shared multiplier only)
//   MUL     | p0, p2 and pm together          (parallel multipliers only)
//   COMBINE | s <= p2<<10 + (pm-p2-p0)<<5 + p0, done <= 1
//   DONE    | result valid and held, waiting for the next start

module karatsuba_10b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  a,
    input  logic [9:0]  b,
    output logic [19:0] s,
    output logic        done
);

`ifdef KARATSUBA_SHARED_MUL_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_LO  = 3'd1,
        MUL_HI  = 3'd2,
        MUL_MID = 3'd3,
        COMBINE = 3'd4,
        DONE    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL     = 3'd1,
        COMBINE = 3'd4,
        DONE    = 3'd5
    } state_t;
`endif

    state_t state, state_nxt;

    logic accept;
    logic ld_p0, ld_p2, ld_pm, ld_s;

    logic [9:0]  a_r, b_r;
    logic [4:0]  a1, a0, b1, b0;
    logic [5:0]  sa, sb;
    logic [9:0]  p0, p2;
    logic [11:0] pm;
    logic [9:0]  p0_c, p2_c;
    logic [11:0] pm_c;
    logic [10:0] mid;
    logic [19:0] s_c;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
`ifdef KARATSUBA_SHARED_MUL_EN
            IDLE:    if (start) state_nxt = MUL_LO;
            MUL_LO:  state_nxt = MUL_HI;
            MUL_HI:  state_nxt = MUL_MID;
            MUL_MID: state_nxt = COMBINE;
            COMBINE: state_nxt = DONE;
            DONE:    if (start) state_nxt = MUL_LO;
`else
            IDLE:    if (start) state_nxt = MUL;
            MUL:     state_nxt = COMBINE;
            COMBINE: state_nxt = DONE;
            DONE:    if (start) state_nxt = MUL;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control outputs
    // ------------------------------------------------------------------
    always_comb begin
        accept = 1'b0;
        ld_p0  = 1'b0;
        ld_p2  = 1'b0;
        ld_pm  = 1'b0;
        ld_s   = 1'b0;
        case (state)
            IDLE:    accept = start;
            DONE:    accept = start;
`ifdef KARATSUBA_SHARED_MUL_EN
            MUL_LO:  ld_p0 = 1'b1;
            MUL_HI:  ld_p2 = 1'b1;
            MUL_MID: ld_pm = 1'b1;
`else
            MUL: begin
                ld_p0 = 1'b1;
                ld_p2 = 1'b1;
                ld_pm = 1'b1;
            end
`endif
            COMBINE: ld_s = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand split and half sums
    // ------------------------------------------------------------------
    assign a1 = a_r[9:5];
    assign a0 = a_r[4:0];
    assign b1 = b_r[9:5];
    assign b0 = b_r[4:0];
    assign sa = {1'b0, a1} + {1'b0, a0};
    assign sb = {1'b0, b1} + {1'b0, b0};

`ifdef KARATSUBA_SHARED_MUL_EN
    // One 6x6 multiplier; its operands are steered by the current state.
    logic [5:0]  mul_x, mul_y;
    logic [11:0] mul_p;

    always_comb begin
        mul_x = 6'd0;
        mul_y = 6'd0;
        case (state)
            MUL_LO: begin
                mul_x = {1'b0, a0};
                mul_y = {1'b0, b0};
            end
            MUL_HI: begin
                mul_x = {1'b0, a1};
                mul_y = {1'b0, b1};
            end
            MUL_MID: begin
                mul_x = sa;
                mul_y = sb;
            end
            default: ;
        endcase
    end

    assign mul_p = {6'd0, mul_x} * {6'd0, mul_y};

    // 5-bit operands never produce more than 10 significant bits.
    assign p0_c = 10'(mul_p);
    assign p2_c = 10'(mul_p);
    assign pm_c = mul_p;
`else
    assign p0_c = {5'd0, a0} * {5'd0, b0};
    assign p2_c = {5'd0, a1} * {5'd0, b1};
    assign pm_c = {6'd0, sa} * {6'd0, sb};
`endif

    // ------------------------------------------------------------------
    // Recombination. pm - p2 - p0 equals a1*b0 + a0*b1, which is at most
    // 2*31*31 = 1922, so it is never negative and fits in 11 bits.
    // ------------------------------------------------------------------
    assign mid = 11'(pm - {2'd0, p2} - {2'd0, p0});
    assign s_c = {p2, 10'd0} + {4'd0, mid, 5'd0} + {10'd0, p0};

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= 10'd0;
            b_r  <= 10'd0;
            p0   <= 10'd0;
            p2   <= 10'd0;
            pm   <= 12'd0;
            s    <= 20'd0;
            done <= 1'b0;
        end else begin
            if (accept) begin
                a_r  <= a;
                b_r  <= b;
                done <= 1'b0;
            end
            if (ld_p0) p0 <= p0_c;
            if (ld_p2) p2 <= p2_c;
            if (ld_pm) pm <= pm_c;
            // s keeps its previous value until the new result is ready.
            if (ld_s) begin
                s    <= s_c;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_karatsuba_10b.sv
module tb_karatsuba_10b;

`ifdef KARATSUBA_SHARED_MUL_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  a;
    logic [9:0]  b;
    logic [19:0] s;
    logic        done;

    int total;
    int bad;
    logic [19:0] exp_q[$];
    logic [19:0] last_exp;

    karatsuba_10b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .s     (s),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Drive one operation and compare against the scoreboard when done rises.
    task automatic run_op(input logic [9:0] ta, input logic [9:0] tb_, input logic [19:0] expv,
                          input int hold, input bit verbose);
        logic [19:0] s_old;
        logic [19:0] got_s;
        int cyc;
        bit got;
        @(negedge clk);
        s_old = s;
        a     = ta;
        b     = tb_;
        start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        // operands change after the accepting edge must not matter
        a = ~ta;
        b = ~tb_;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_clear: got done=%b want 0 (a=%0d b=%0d)", done, ta, tb_);
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            start = (i + 1 < hold);
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
            end else if (verbose) begin
                total++;
                if (s !== s_old) begin
                    bad++;
                    $display("FAIL s_retain: got s=%0d want %0d while busy", s, s_old);
                end
            end
        end
        start = 1'b0;
        got_s = exp_q.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL done_timeout: done never rose for a=%0d b=%0d", ta, tb_);
        end else begin
            if (s !== got_s) begin
                bad++;
                $display("FAIL product: a=%0d b=%0d got s=%0d want %0d", ta, tb_, s, got_s);
            end
            if (verbose) begin
                total++;
                if (cyc != LAT) begin
                    bad++;
                    $display("FAIL latency: got %0d edges want %0d", cyc, LAT);
                end
            end
        end
        last_exp = got_s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = 10'd0;
        b     = 10'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (done !== 1'b0 || s !== 20'd0) begin
            bad++;
            $display("FAIL reset_in: got done=%b s=%0d want 0/0", done, s);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || s !== 20'd0) begin
                bad++;
                $display("FAIL reset_idle: cycle %0d got done=%b s=%0d want 0/0", i, done, s);
            end
        end
    endtask

    task automatic test_max_hold();
        run_op(10'd1023, 10'd1023, 20'd1046529, 2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b1 || s !== 20'h FF801) begin
                bad++;
                $display("FAIL max_hold: got done=%b s=%0d want 1/1046529", done, s);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [9:0]  ta [6] = '{10'd31, 10'd32, 10'd1023, 10'd0,   10'd1023, 10'd992};
        logic [9:0]  tbv[6] = '{10'd31, 10'd32, 10'd1,    10'd777, 10'd0,    10'd31};
        logic [19:0] te [6] = '{20'd961, 20'd1024, 20'd1023, 20'd0, 20'd0, 20'd30752};
        for (int i = 0; i < 6; i++) run_op(ta[i], tbv[i], te[i], 1, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_op(10'd500, 10'd3, 20'd1500, 2, 1'b1);
        run_op(10'd17, 10'd999, 20'd16983, 1, 1'b1);
        run_op(10'd1000, 10'd1000, 20'd1000000, 3, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a     = 10'd600;
        b     = 10'd700;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (s !== 20'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got s=%0d done=%b want 0/0", s, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (s !== 20'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: got s=%0d done=%b want 0/0", s, done);
        end
        run_op(10'd600, 10'd700, 20'd420000, 2, 1'b1);
    endtask

    task automatic test_random();
        logic [9:0] ra, rb;
        for (int i = 0; i < 1000; i++) begin
            ra = 10'($urandom_range(0, 1023));
            rb = 10'($urandom_range(0, 1023));
            run_op(ra, rb, 20'(ra) * 20'(rb), 2, 1'b0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_max_hold();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
